// File: rtl/shot_detector_if.sv
// vga_if: composed pixel stream bundle (timing counters, blanking flags, colour).
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;
    modport in  (input  vcount, hcount, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vblnk, hblnk, rgb);
endinterface

// File: rtl/shot_detector.sv
// shot_detector: latches the cursor on a click, scans a window of the next full frame
// for target-coloured pixels, pulses hit or miss, then holds off for a frame-counted reload.
module shot_detector #(
    parameter logic [11:0] TARGET_RGB      = 12'hF00,
    parameter logic [11:0] TARGET_MASK     = 12'hFFF,
    parameter int unsigned WIN             = 2,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    vga_if.in           in,
    output logic        hit,
    output logic        miss,
    output logic        busy,
    output logic [11:0] shot_x,
    output logic [11:0] shot_y
);
    localparam int unsigned CW      = (COOLDOWN_FRAMES == 0) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW:0] CNT_END = (CW + 1)'(COOLDOWN_FRAMES);
    localparam logic [12:0] W13     = 13'(WIN);

    typedef enum logic [2:0] {IDLE, WAIT_SOF, SCAN, REPORT, COOLDOWN} state_e;

    state_e          state_q, state_d;
    logic            left_q, vblnk_q;
    logic            flag_q, flag_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [12:0]     xl_q, xh_q, yl_q, yh_q;
    logic [12:0]     xl_d, xh_d, yl_d, yh_d;
    logic [11:0]     shot_x_q, shot_y_q, shot_x_d, shot_y_d;
    logic            hit_q, miss_q, hit_d, miss_d;
    logic            click, sof, vb_rise, in_win, pix_match;
    logic [12:0]     hc13, vc13;

    assign hc13      = {2'b00, in.hcount};
    assign vc13      = {2'b00, in.vcount};
    assign click     = left && !left_q;
    assign sof       = in.vcount == '0 && in.hcount == '0;
    assign vb_rise   = in.vblnk && !vblnk_q;
    assign in_win    = hc13 >= xl_q && hc13 <= xh_q && vc13 >= yl_q && vc13 <= yh_q;
    assign pix_match = !in.hblnk && !in.vblnk && in_win &&
                       (in.rgb & TARGET_MASK) == (TARGET_RGB & TARGET_MASK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            left_q   <= 1'b0;
            vblnk_q  <= 1'b0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
            xl_q     <= '0;
            xh_q     <= '0;
            yl_q     <= '0;
            yh_q     <= '0;
            shot_x_q <= '0;
            shot_y_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left;
            vblnk_q  <= in.vblnk;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
            xl_q     <= xl_d;
            xh_q     <= xh_d;
            yl_q     <= yl_d;
            yh_q     <= yh_d;
            shot_x_q <= shot_x_d;
            shot_y_q <= shot_y_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        flag_d   = flag_q;
        cnt_d    = cnt_q;
        xl_d     = xl_q;
        xh_d     = xh_q;
        yl_d     = yl_q;
        yh_d     = yh_q;
        shot_x_d = shot_x_q;
        shot_y_d = shot_y_q;
        unique case (state_q)
            IDLE: if (click) begin
                state_d  = WAIT_SOF;
                flag_d   = 1'b0;
                shot_x_d = xpos;
                shot_y_d = ypos;
                // clamp the low edge so a corner click never wraps to the far side
                xl_d     = {1'b0, xpos} < W13 ? '0 : {1'b0, xpos} - W13;
                yl_d     = {1'b0, ypos} < W13 ? '0 : {1'b0, ypos} - W13;
                xh_d     = {1'b0, xpos} + W13;
                yh_d     = {1'b0, ypos} + W13;
            end
            WAIT_SOF: if (sof) begin
                state_d = SCAN;
                flag_d  = flag_q | pix_match;
            end
            SCAN: begin
                flag_d = flag_q | pix_match;
                if (vb_rise) state_d = REPORT;
            end
            REPORT: begin
                state_d = (COOLDOWN_FRAMES == 0) ? IDLE : COOLDOWN;
                cnt_d   = '0;
            end
            COOLDOWN: if (sof) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ({1'b0, cnt_q} + 1'b1 == CNT_END) ? IDLE : COOLDOWN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = state_q != IDLE;
        hit_d  = state_q == REPORT && flag_q;
        miss_d = state_q == REPORT && !flag_q;
    end

    assign hit    = hit_q;
    assign miss   = miss_q;
    assign shot_x = shot_x_q;
    assign shot_y = shot_y_q;
endmodule

// File: tb/tb_shot_detector.sv
// tb_shot_detector: two detectors (full mask with 3-frame cooldown, red-only mask without
// cooldown) on one small-frame stream, checked every cycle against a frame-arithmetic model.
module tb_shot_detector;
    localparam int HACT = 24, HT = 32, VACT = 16, VT = 20, FRAME = HT * VT;
    localparam int WIN = 2, NCD = 3;

    logic        clk = 1'b0, rst = 1'b0, left = 1'b0;
    logic [11:0] xpos = '0, ypos = '0;
    logic [1:0]  hit, miss, busy;
    logic [11:0] shot_x [2], shot_y [2];
    logic [11:0] scene [VACT][HACT];
    int          n_tests = 0, n_fail = 0;

    vga_if vga();

    always #5 clk = ~clk;

    shot_detector #(.COOLDOWN_FRAMES(NCD)) dut_a (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left), .in(vga),
        .hit(hit[0]), .miss(miss[0]), .busy(busy[0]), .shot_x(shot_x[0]), .shot_y(shot_y[0]));

    shot_detector #(.TARGET_MASK(12'hF00), .COOLDOWN_FRAMES(0)) dut_b (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .left(left), .in(vga),
        .hit(hit[1]), .miss(miss[1]), .busy(busy[1]), .shot_x(shot_x[1]), .shot_y(shot_y[1]));

    task automatic check(input string tag, input int d, input logic [11:0] got, input logic [11:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", tag, d, $time, got, exp);
        end
    endtask

    // Does any on-screen pixel of the clipped window match the masked target colour?
    function automatic bit window_hit(input int x, input int y, input logic [11:0] m);
        for (int yy = y - WIN; yy <= y + WIN; yy++)
            for (int xx = x - WIN; xx <= x + WIN; xx++)
                if (xx >= 0 && yy >= 0 && xx < HACT && yy < VACT &&
                    (scene[yy][xx] & m) == (12'hF00 & m)) return 1'b1;
        return 1'b0;
    endfunction

    // Stream: raster position advances one pixel per clock; blanking carries target colour.
    initial begin
        int pos = 0;
        vga.hcount = '0; vga.vcount = '0; vga.hblnk = 1'b0; vga.vblnk = 1'b0; vga.rgb = '0;
        forever begin
            @(negedge clk);
            vga.hcount = 11'(pos % HT);
            vga.vcount = 11'(pos / HT);
            vga.hblnk  = (pos % HT) >= HACT;
            vga.vblnk  = (pos / HT) >= VACT;
            vga.rgb    = (vga.hblnk || vga.vblnk) ? 12'hF00 : scene[pos / HT][pos % HT];
            pos = (pos + 1) % FRAME;
        end
    end

    // Model: per accepted click, predict report sample and busy end from frame arithmetic.
    longint      s = 0;
    bit          act [2] = '{0, 0};
    bit          res [2];
    longint      rep [2], c_end [2];
    logic [11:0] msx [2] = '{0, 0}, msy [2] = '{0, 0};
    logic        lprev = 1'b0;

    initial forever begin
        longint k;
        int p;
        @(posedge clk);
        s++;
        p = int'(vga.vcount) * HT + int'(vga.hcount);
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                act[d] = 1'b0; msx[d] = '0; msy[d] = '0;
            end else if (left && !lprev && !(act[d] && s - 1 < c_end[d])) begin
                act[d]   = 1'b1;
                msx[d]   = xpos;
                msy[d]   = ypos;
                k        = s + FRAME - p;
                rep[d]   = k + VACT * HT + 1;
                c_end[d] = (d == 0) ? k + NCD * FRAME : rep[d];
                res[d]   = window_hit(int'(xpos), int'(ypos), d == 0 ? 12'hFFF : 12'hF00);
            end
        end
        lprev = rst ? left : 1'b0;
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("busy",   d, 12'(busy[d]), 12'(act[d] && s < c_end[d]));
                check("hit",    d, 12'(hit[d]),  12'(act[d] && s == rep[d] && res[d]));
                check("miss",   d, 12'(miss[d]), 12'(act[d] && s == rep[d] && !res[d]));
                check("shot_x", d, shot_x[d], msx[d]);
                check("shot_y", d, shot_y[d], msy[d]);
            end
        end
    end

    task automatic clear_scene();
        for (int y = 0; y < VACT; y++)
            for (int x = 0; x < HACT; x++) scene[y][x] = 12'h000;
    endtask

    task automatic put_block(input int x0, input int y0, input int w, input int h, input logic [11:0] c);
        for (int y = y0; y < y0 + h && y < VACT; y++)
            for (int x = x0; x < x0 + w && x < HACT; x++) scene[y][x] = c;
    endtask

    task automatic wait_idle();
        int i = 0;
        while (busy != 2'b00 && i < 8 * FRAME) begin
            @(negedge clk);
            i++;
        end
        check("idle_wait", 0, {10'b0, busy}, 12'h000);
        repeat (2) @(negedge clk);
    endtask

    task automatic shoot(input int x, input int y, input bit spam);
        @(negedge clk);
        xpos = 12'(x);
        ypos = 12'(y);
        repeat ($urandom_range(1, FRAME)) @(negedge clk);
        left = 1'b1;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        left = 1'b0;
        @(negedge clk);
        xpos = 12'($urandom);
        ypos = 12'($urandom);
        if (spam)
            for (int i = 0; i < 200 && busy[0]; i++) begin
                repeat ($urandom_range(20, 150)) @(negedge clk);
                left = ~left;
            end
        left = 1'b0;
        wait_idle();
    endtask

    task automatic shoot_reset(input int x, input int y);
        int i = 0;
        @(negedge clk);
        xpos = 12'(x);
        ypos = 12'(y);
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        @(negedge clk);
        while (!(vga.vcount == 0 && vga.hcount == 0) && i < 2 * FRAME) begin
            @(negedge clk);
            i++;
        end
        repeat (100) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] c;
        int bx, by;
        clear_scene();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        put_block(14, 10, 5, 5, 12'hF00);
        shoot(15, 9, 1'b0);
        shoot(3, 3, 1'b0);
        clear_scene();
        put_block(0, 0, 1, 1, 12'hF00);
        shoot(1, 1, 1'b0);
        clear_scene();
        put_block(HACT - 1, VACT - 1, 1, 1, 12'hF00);
        shoot(0, 0, 1'b0);
        shoot(HACT + 1, VACT + 1, 1'b0);
        clear_scene();
        put_block(14, 10, 5, 5, 12'hF00);
        shoot(16, 12, 1'b1);
        shoot_reset(16, 12);
        shoot(16, 12, 1'b0);
        clear_scene();
        put_block(8, 8, 1, 1, 12'hF3A);
        shoot(9, 9, 1'b0);
        clear_scene();
        put_block(8, 8, 1, 1, 12'hE00);
        shoot(9, 9, 1'b0);
        for (int n = 0; n < 6; n++) begin
            clear_scene();
            bx = $urandom_range(0, HACT - 1);
            by = $urandom_range(0, VACT - 1);
            for (int b = 0; b < 3; b++) begin
                case ($urandom_range(0, 3))
                    0: c = 12'hF00;
                    1: c = 12'hF3A;
                    2: c = 12'hE00;
                    default: c = 12'($urandom);
                endcase
                put_block(b == 0 ? bx : $urandom_range(0, HACT - 1), b == 0 ? by : $urandom_range(0, VACT - 1),
                          $urandom_range(1, 3), $urandom_range(1, 3), c);
            end
            if ($urandom_range(0, 1) == 1)
                shoot(bx + $urandom_range(0, 4) - 2 < 0 ? 0 : bx + $urandom_range(0, 4) - 2,
                      by + $urandom_range(0, 4) - 2 < 0 ? 0 : by + $urandom_range(0, 4) - 2, 1'($urandom));
            else
                shoot($urandom_range(0, HACT + 3), $urandom_range(0, VACT + 3), 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shot_detector.md
Name: shot_detector

Overview:
- Sink-side consumer of the VGA pixel stream for the Duck Hunt game.
- On a left mouse click, latches the cursor position and samples the composed frame's RGB in a small window around it on the next full frame.
- Reports a one-cycle hit or miss pulse to the game logic, then enforces a reload cooldown measured in frames.
- Taps the final vga_if stream after all overlays except the crosshair, so crosshair pixels never mask targets.

Parameters:
- TARGET_RGB, 12'hF00, colour that counts as a target pixel.
- TARGET_MASK, 12'hFFF, bit mask applied to both sampled rgb and TARGET_RGB before comparison.
- WIN, 2, window half-size in pixels; window is (2*WIN+1) x (2*WIN+1), centred on the latched position.
- COOLDOWN_FRAMES, 30, frames ignored after each report; 0 means no cooldown.

Ports:
- clk  in  1  pixel clock, same domain as the vga_if stream.
- rst  in  1  reset; synchronous, active-low.
- xpos  in  12  cursor x, pixel units.
- ypos  in  12  cursor y, pixel units.
- left  in  1  left mouse button level, already synchronised to clk.
- in  vga_if.in  -  VGA stream; uses vcount, hcount, vblnk, hblnk, rgb. No vga_if output.
- hit  out  1  one-cycle pulse: window contained at least one target pixel.
- miss  out  1  one-cycle pulse: window contained no target pixel.
- busy  out  1  high in every state except IDLE.
- shot_x  out  12  latched x of the last shot.
- shot_y  out  12  latched y of the last shot.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - hit, miss, busy, shot_x, shot_y all become 0.
  - Match flag, cooldown counter and left edge register are cleared.
  - Applies from any state, including mid-SCAN; a shot in progress is discarded with no pulse.
- Click detect: rising edge of left (registered left==0, current left==1). Only acted on in IDLE. Edges in any other state are dropped, not queued.
- SOF: in.vcount==0 && in.hcount==0.
- State machine:
  - IDLE: on click, latch shot_x=xpos and shot_y=ypos, clear the match flag, go to WAIT_SOF.
  - WAIT_SOF: on SOF go to SCAN. The SOF pixel is itself evaluated in SCAN, so no window pixel is missed.
  - SCAN: for each pixel, if all of the following hold, set the match flag:
    - hblnk==0 and vblnk==0;
    - hcount is in [xl, xh] and vcount is in [yl, yh];
    - (rgb & TARGET_MASK) == (TARGET_RGB & TARGET_MASK).
    - On the rising edge of in.vblnk (registered 0, current 1), go to REPORT.
  - REPORT: lasts exactly one cycle. hit=flag, miss=~flag, both registered. Then go to COOLDOWN, or to IDLE if COOLDOWN_FRAMES==0.
  - COOLDOWN: counter counts SOF events. Return to IDLE when the count reaches COOLDOWN_FRAMES.
- Window bounds, computed once on entry to WAIT_SOF using 13-bit arithmetic:
  - xl = max(shot_x - WIN, 0); xh = shot_x + WIN. yl and yh likewise.
  - No wrap-around at the top-left corner.
  - Window parts beyond the active area fall in blanking and are ignored.
- Latency: hit/miss assert 1 cycle after the first vblnk rising edge that follows the first SOF after the click. At most about 2 frames from the click.
- Position changes after the latch have no effect on the current shot.
- hit and miss are never high simultaneously and are never high outside REPORT+1.

Test Plan:
- 800x600 frame, 5x5 block of 12'hF00 at (400,300); click at xpos=401, ypos=299 mid-frame -> busy=1 next cycle; single hit pulse after the next frame's vblnk rise; shot_x=401, shot_y=299.
- Same scene, click at (100,100) -> single miss pulse, no hit.
- Click at (1,1), WIN=2, target pixel at (0,0) -> hit, with no window underflow/wrap. Separately, target only at (799,599) with click at (0,0) -> miss.
- COOLDOWN_FRAMES=3: clicks issued during COOLDOWN -> ignored, no pulses. busy stays 1 for exactly 3 SOFs after REPORT; a click after busy falls is accepted.
- Assert rst=0 during SCAN with a target inside the window -> no hit/miss; all outputs 0; the next click runs a full normal shot.
- TARGET_MASK=12'hF00, window pixel rgb=12'hF3A -> hit. Pixel rgb=12'hE00 -> miss.
